lsu_mem_port: RTL

- Load/store stage directly downstream of the ALU.
- Consumes the ALU result as the effective address for LW/SW and drives a request/grant/response data-memory bus.
- Stalls the single-cycle core until the access completes, then returns load data to the writeback mux.
- Adds misalignment detection and a bus-timeout watchdog, so a hung memory cannot deadlock the core.

---
 rtl/lsu_mem_port.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_port
// Brief    : Load/store stage with req/gnt/rvalid memory bus, misalignment
//            rejection and bus-timeout watchdog. Define LSU_SUBWORD_EN to add
//            byte/halfword accesses decoded from req_size (funct3).
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_port #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_size,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic             r_we;
    logic             r_bus_err;

    logic             w_aligned;
    logic             w_launch;
    logic             w_reject;
    logic             w_cnt_last;
    logic [3:0]       w_strb;
    logic [31:0]      w_bus_wdata;
    logic [31:0]      w_load_data;

`ifdef LSU_SUBWORD_EN
    logic [2:0]       r_size;
    logic [31:0]      w_lane;

    always_comb begin
        w_aligned = 1'b1;
        case (req_size[1:0])
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = ~req_addr[0];
            default: w_aligned = (req_addr[1:0] == 2'b00);
        endcase
    end

    always_comb begin
        w_strb      = 4'hF;
        w_bus_wdata = r_wdata;
        case (r_size[1:0])
            2'b00: begin
                w_strb      = 4'b0001 << r_addr[1:0];
                w_bus_wdata = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_strb      = 4'b0011 << r_addr[1:0];
                w_bus_wdata = {2{r_wdata[15:0]}};
            end
            default: begin
                w_strb      = 4'hF;
                w_bus_wdata = r_wdata;
            end
        endcase
    end

    // Addressed lane moved down to bit 0 before extension
    assign w_lane = mem_rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_load_data = mem_rdata;
        case (r_size)
            3'b000:  w_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b100:  w_load_data = {24'h0, w_lane[7:0]};
            3'b101:  w_load_data = {16'h0, w_lane[15:0]};
            default: w_load_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_size <= 3'b000;
        end else if (r_state == c_st_idle && w_launch) begin
            r_size <= req_size;
        end
    end
`else
    logic w_unused_bits;

    assign w_aligned     = (req_addr[1:0] == 2'b00);
    assign w_strb        = 4'hF;
    assign w_bus_wdata   = r_wdata;
    assign w_load_data   = mem_rdata;
    assign w_unused_bits = ^{req_size, r_addr[1:0]};
`endif

    assign w_launch   = req_valid & w_aligned;
    assign w_reject   = req_valid & ~w_aligned;
    assign w_cnt_last = (r_cnt == c_cnt_last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_launch) begin
                    w_next = c_st_req;
                end
            end
            c_st_req: begin
                // Stores are posted: the grant alone completes them
                if (mem_gnt) begin
                    w_next = r_we ? c_st_done : c_st_wait;
                end else if (w_cnt_last) begin
                    w_next = c_st_done;
                end
            end
            c_st_wait: begin
                if (mem_rvalid || w_cnt_last) begin
                    w_next = c_st_done;
                end
            end
            c_st_done: begin
                w_next = c_st_idle;
            end
            default: begin
                w_next = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_rdata   <= 32'h0;
            r_we      <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_launch) begin
                        r_addr    <= req_addr;
                        r_wdata   <= req_wdata;
                        r_we      <= req_we;
                        r_cnt     <= '0;
                        r_rdata   <= 32'h0;
                        r_bus_err <= 1'b0;
                    end
                end
                c_st_req: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!mem_gnt && w_cnt_last) begin
                        r_bus_err <= 1'b1;
                    end
                end
                c_st_wait: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (mem_rvalid) begin
                        r_rdata <= w_load_data;
                    end else if (w_cnt_last) begin
                        r_bus_err <= 1'b1;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    always_comb begin
        stall        = 1'b0;
        done         = 1'b0;
        misalign_err = 1'b0;
        bus_err      = 1'b0;
        rdata        = 32'h0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = 32'h0;
        mem_wdata    = 32'h0;
        mem_wstrb    = 4'h0;
        case (r_state)
            c_st_idle: begin
                // Misaligned requests retire at once with no bus traffic
                stall        = w_launch;
                misalign_err = w_reject;
                done         = w_reject;
            end
            c_st_req: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = r_we;
                mem_addr  = {r_addr[31:2], 2'b00};
                mem_wdata = w_bus_wdata;
                mem_wstrb = w_strb;
            end
            c_st_wait: begin
                stall = 1'b1;
            end
            c_st_done: begin
                done    = 1'b1;
                bus_err = r_bus_err;
                rdata   = r_rdata;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire
